logic_unit_arbiter: RTL and testbench
=====================================

Name: logic_unit_arbiter

Overview:
- Shares one 32-bit bitwise logic unit (AND / OR / NOR / INV) between two requesters.
- Arbitrates round-robin and sequences each operation through a 3-state FSM.
- Returns a registered result with a one-cycle DONE pulse to the winning requester.
- Sits between the control unit and the logic datapath, so both ALU-side and address-side clients can use one logic unit.

Parameters:
- DATA_WIDTH, 32, operand/result width; the datapath is built from the team's 32-bit logic cells.
- CNT_WIDTH, 16, width of the completed-operation counter.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RST  input  1  asynchronous active-high reset.
- REQ0  input  1  requester 0 operation request (level).
- OP0  input  2  requester 0 opcode.
- A0  input  DATA_WIDTH  requester 0 operand A.
- B0  input  DATA_WIDTH  requester 0 operand B.
- REQ1, OP1, A1, B1  input  1/2/DATA_WIDTH/DATA_WIDTH  same for requester 1.
- GNT0  output  1  requester 0 owns the unit.
- GNT1  output  1  requester 1 owns the unit.
- DONE0  output  1  one-cycle completion pulse, requester 0.
- DONE1  output  1  one-cycle completion pulse, requester 1.
- RESULT  output  DATA_WIDTH  registered result of the last completed operation.
- BUSY  output  1  FSM not in IDLE.
- OP_COUNT  output  CNT_WIDTH  number of completed operations.

Behaviour:
- Clock and reset: one clock, CLK. RST is asynchronous and active-high.
- Reset values: all outputs 0; FSM = IDLE; internal last-served pointer LAST = 1, so requester 0 wins the first tie.
- Opcodes (RESULT bitwise):
  - 2'b00 AND: A & B.
  - 2'b01 OR: A | B.
  - 2'b10 NOR: ~(A | B).
  - 2'b11 INV: ~A, B ignored.
- Requester protocol:
  - Raise REQx and hold OPx/Ax/Bx stable until DONEx is sampled high.
  - REQx must be low by the edge after the one where DONEx is sampled high; otherwise it counts as a new request.
- FSM IDLE, on each edge:
  - No REQ: stay in IDLE.
  - Exactly one REQx: grant x.
  - Both REQ: grant the requester != LAST.
  - On grant: capture opcode/A/B into internal registers, set GNTx = 1, set BUSY = 1, set LAST = x, go to EXEC.
- FSM EXEC, next edge: RESULT <= f(captured op, A, B); DONEx <= 1; OP_COUNT <= OP_COUNT + 1 (wraps modulo 2^CNT_WIDTH); go to RESP.
- FSM RESP, next edge: DONEx <= 0, GNTx <= 0, BUSY <= 0; go to IDLE. New requests are evaluated from IDLE on the following edge.
- Latency and throughput:
  - Grant visible 1 cycle after REQ is sampled; RESULT/DONE visible 2 cycles after.
  - Back-to-back throughput is one operation per 3 cycles.
- Invariants:
  - GNT0 and GNT1 are never high together.
  - DONEx is high only while GNTx is high.
  - RESULT changes only on the EXEC->RESP edge and otherwise holds its value.
- Operand changes after grant have no effect, since operands are captured.
- REQx dropped during EXEC/RESP: the transaction still completes and DONEx still pulses.
- Fairness: under continuous requests from both sides, grants alternate strictly 0,1,0,1…
- RST asserted mid-transaction: immediate abort; no DONE pulse; RESULT and OP_COUNT cleared to 0; LAST = 1.
- No X propagation: unselected requester inputs never reach RESULT.

Test Plan:
- Reset, then REQ0=1, OP0=00, A0=0xF0F0F0F0, B0=0x0FF00FF0 -> GNT0 high after edge 1; RESULT=0x00F000F0 and DONE0=1 after edge 2; GNT0=0, BUSY=0 after edge 3; OP_COUNT=1.
- Requester 1 alone with OP1=01/10/11 on the same operands (A1=0x12345678 for INV) -> RESULT = 0xFFF0FFF0, 0x000F000F, 0xEDCBA987 respectively; GNT0 never asserted.
- REQ0 and REQ1 held high continuously for 4 operations -> grant order 0,1,0,1; one DONE pulse per grant; OP_COUNT=4; GNT0 & GNT1 never both 1.
- After grant to requester 0, change A0 to 0xFFFFFFFF during EXEC -> RESULT reflects the captured operand, not the new value.
- Assert RST during EXEC -> all outputs 0 asynchronously (before next edge), no DONE pulse; after release, a simultaneous request is granted to requester 0 first.
- Preload OP_COUNT to all-ones via 2^16−1 operations (or force), complete one more -> OP_COUNT wraps to 0.

Source files
------------

// File: rtl/logic_unit_arbiter.sv
// logic_unit_arbiter: round-robin share of one bitwise logic unit between two requesters
module logic_unit_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  REQ0,
    input  logic [1:0]            OP0,
    input  logic [DATA_WIDTH-1:0] A0,
    input  logic [DATA_WIDTH-1:0] B0,
    input  logic                  REQ1,
    input  logic [1:0]            OP1,
    input  logic [DATA_WIDTH-1:0] A1,
    input  logic [DATA_WIDTH-1:0] B1,
    output logic                  GNT0,
    output logic                  GNT1,
    output logic                  DONE0,
    output logic                  DONE1,
    output logic [DATA_WIDTH-1:0] RESULT,
    output logic                  BUSY,
    output logic [CNT_WIDTH-1:0]  OP_COUNT
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t state, state_nx;
    logic last, grant0, grant1;
    logic [1:0] op_q;
    logic [DATA_WIDTH-1:0] a_q, b_q, f;
    always_comb begin
        grant0   = REQ0 & (~REQ1 | last);
        grant1   = REQ1 & ~grant0;
        state_nx = state == IDLE ? ((REQ0 | REQ1) ? EXEC : IDLE) :
                   state == EXEC ? RESP : IDLE;
        f = op_q == 2'b00 ? (a_q & b_q) :
            op_q == 2'b01 ? (a_q | b_q) :
            op_q == 2'b10 ? ~(a_q | b_q) : ~a_q;
    end
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_nx;
    end
    assign BUSY = state != IDLE;
    // Operands are captured at grant so later requester-side changes cannot leak in.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            last     <= 1'b1;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            GNT0     <= 1'b0;
            GNT1     <= 1'b0;
            DONE0    <= 1'b0;
            DONE1    <= 1'b0;
            RESULT   <= '0;
            OP_COUNT <= '0;
        end else if (state == IDLE) begin
            if (grant0 | grant1) begin
                op_q <= grant0 ? OP0 : OP1;
                a_q  <= grant0 ? A0 : A1;
                b_q  <= grant0 ? B0 : B1;
                GNT0 <= grant0;
                GNT1 <= grant1;
                last <= grant1;
            end
        end else if (state == EXEC) begin
            RESULT   <= f;
            DONE0    <= GNT0;
            DONE1    <= GNT1;
            OP_COUNT <= OP_COUNT + 1'b1;
        end else begin
            GNT0  <= 1'b0;
            GNT1  <= 1'b0;
            DONE0 <= 1'b0;
            DONE1 <= 1'b0;
        end
    end
endmodule

// File: tb/tb_logic_unit_arbiter.sv
// tb_logic_unit_arbiter: directed vectors for the shared logic-unit arbiter
module tb_logic_unit_arbiter;
    logic CLK = 0, RST = 0;
    logic REQ0 = 0, REQ1 = 0;
    logic [1:0] OP0 = 0, OP1 = 0;
    logic [31:0] A0 = 0, B0 = 0, A1 = 0, B1 = 0;
    logic GNT0, GNT1, DONE0, DONE1, BUSY;
    logic [31:0] RESULT;
    logic [15:0] OP_COUNT;
    logic s_gnt0, s_gnt1, s_done0, s_done1, s_busy;
    logic [31:0] s_result;
    logic [1:0] s_count;
    int n_chk = 0, n_fail = 0, n_ops = 0;
    bit running = 0;

    always #5 CLK = ~CLK;

    logic_unit_arbiter dut (
        .CLK(CLK), .RST(RST),
        .REQ0(REQ0), .OP0(OP0), .A0(A0), .B0(B0),
        .REQ1(REQ1), .OP1(OP1), .A1(A1), .B1(B1),
        .GNT0(GNT0), .GNT1(GNT1), .DONE0(DONE0), .DONE1(DONE1),
        .RESULT(RESULT), .BUSY(BUSY), .OP_COUNT(OP_COUNT)
    );

    // Narrow counter copy sees the same traffic so counter wrap is reachable quickly.
    logic_unit_arbiter #(.DATA_WIDTH(32), .CNT_WIDTH(2)) u_small (
        .CLK(CLK), .RST(RST),
        .REQ0(REQ0), .OP0(OP0), .A0(A0), .B0(B0),
        .REQ1(REQ1), .OP1(OP1), .A1(A1), .B1(B1),
        .GNT0(s_gnt0), .GNT1(s_gnt1), .DONE0(s_done0), .DONE1(s_done1),
        .RESULT(s_result), .BUSY(s_busy), .OP_COUNT(s_count)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge CLK)
        if (running) chk("invariant", {GNT0 & GNT1, DONE0 & ~GNT0, DONE1 & ~GNT1}, 0);

    task automatic do_op(input bit r, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp);
        if (r) begin REQ1 = 1; OP1 = op; A1 = a; B1 = b; end
        else   begin REQ0 = 1; OP0 = op; A0 = a; B0 = b; end
        @(posedge CLK); #1;
        chk("grant", {GNT0, GNT1, BUSY, DONE0, DONE1}, r ? 5'b01100 : 5'b10100);
        @(posedge CLK); #1;
        n_ops++;
        chk("done", {GNT0, GNT1, BUSY, DONE0, DONE1}, r ? 5'b01101 : 5'b10110);
        chk("result", RESULT, exp);
        chk("count", OP_COUNT, n_ops & 16'hFFFF);
        chk("count_small", s_count, n_ops & 3);
        REQ0 = 0; REQ1 = 0;
        @(posedge CLK); #1;
        chk("idle", {GNT0, GNT1, BUSY, DONE0, DONE1}, 5'b00000);
        chk("result_hold", RESULT, exp);
    endtask

    initial begin
        #2 RST = 1;
        #1;
        chk("reset_outs", {GNT0, GNT1, DONE0, DONE1, BUSY}, 0);
        chk("reset_result", RESULT, 0);
        chk("reset_count", OP_COUNT, 0);
        @(negedge CLK); @(negedge CLK);
        RST = 0;
        running = 1;
        @(posedge CLK); #1;

        do_op(0, 2'b00, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0);
        do_op(1, 2'b01, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0);
        do_op(1, 2'b10, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h000F000F);
        do_op(1, 2'b11, 32'h12345678, 32'h0FF00FF0, 32'hEDCBA987);

        // Both requesters held high: strict alternation starting with 0
        REQ0 = 1; OP0 = 2'b00; A0 = 32'hF0F0F0F0; B0 = 32'h0FF00FF0;
        REQ1 = 1; OP1 = 2'b01; A1 = 32'hF0F0F0F0; B1 = 32'h0FF00FF0;
        for (int i = 0; i < 12; i++) begin
            @(posedge CLK); #1;
            if (i % 3 == 0)
                chk("fair_gnt", {GNT0, GNT1, BUSY, DONE0, DONE1}, (i / 3) % 2 ? 5'b01100 : 5'b10100);
            else if (i % 3 == 1) begin
                n_ops++;
                chk("fair_done", {GNT0, GNT1, BUSY, DONE0, DONE1}, (i / 3) % 2 ? 5'b01101 : 5'b10110);
                chk("fair_result", RESULT, (i / 3) % 2 ? 32'hFFF0FFF0 : 32'h00F000F0);
            end else
                chk("fair_idle", {GNT0, GNT1, BUSY, DONE0, DONE1}, 5'b00000);
        end
        REQ0 = 0; REQ1 = 0;
        chk("fair_count", OP_COUNT, 8);
        chk("wrap_small", s_count, 0);

        // Operand change after grant must not affect the result
        REQ0 = 1; OP0 = 2'b00; A0 = 32'hF0F0F0F0; B0 = 32'h0FF00FF0;
        @(posedge CLK); #1;
        chk("cap_grant", {GNT0, GNT1, BUSY}, 3'b101);
        A0 = 32'hFFFFFFFF;
        @(posedge CLK); #1;
        n_ops++;
        chk("cap_result", RESULT, 32'h00F000F0);
        chk("cap_done", DONE0, 1);
        REQ0 = 0;
        @(posedge CLK); #1;

        // Asynchronous abort during EXEC
        REQ0 = 1; OP0 = 2'b01;
        @(posedge CLK); #1;
        chk("abort_grant", {GNT0, BUSY}, 2'b11);
        #2 RST = 1;
        #1;
        chk("abort_outs", {GNT0, GNT1, DONE0, DONE1, BUSY}, 0);
        chk("abort_result", RESULT, 0);
        chk("abort_count", OP_COUNT, 0);
        @(posedge CLK); #1;
        chk("abort_nodone", {DONE0, DONE1}, 0);
        @(negedge CLK);
        RST = 0;
        n_ops = 0;
        REQ0 = 1; OP0 = 2'b10; A0 = 32'hF0F0F0F0; B0 = 32'h0FF00FF0;
        REQ1 = 1; OP1 = 2'b11; A1 = 32'h12345678;
        @(posedge CLK); #1;
        chk("post_rst_gnt", {GNT0, GNT1}, 2'b10);
        @(posedge CLK); #1;
        chk("post_rst_result", RESULT, 32'h000F000F);
        chk("post_rst_count", OP_COUNT, 1);
        REQ0 = 0;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        chk("post_rst_gnt1", {GNT0, GNT1}, 2'b01);
        @(posedge CLK); #1;
        chk("post_rst_result1", RESULT, 32'hEDCBA987);
        REQ1 = 0;
        @(posedge CLK); #1;
        running = 0;
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
